// File: rtl/alu_pkg.sv
// Shared ALU definitions: control codes used by the issue stage and the
// execute-stage logical, arithmetic and shift units, plus decode constants.
package alu_pkg;

    typedef enum logic [3:0] {
        AluAdd     = 4'b0000,
        AluSub     = 4'b0001,
        AluAnd     = 4'b0010,
        AluOr      = 4'b0011,
        AluXor     = 4'b0100,
        AluSll     = 4'b0101,
        AluSrl     = 4'b0110,
        AluSra     = 4'b0111,
        AluSlt     = 4'b1000,
        AluSltu    = 4'b1001,
        AluIllegal = 4'b1111
    } alu_ctrl_t;

    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational RV32I OP / OP-IMM decoder producing the ALU control code,
// an illegal flag and the operand-B select.
module alu_ctrl_decode
    import alu_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output alu_ctrl_t  alu_ctrl,
    output logic       illegal,
    output logic       use_imm
);

    always_comb begin
        alu_ctrl = AluIllegal;
        illegal  = 1'b1;
        // Operand B follows the opcode class even when the encoding is illegal.
        use_imm  = (opcode == OPC_OPIMM);

        unique case (opcode)
            OPC_OP: begin
                if (funct7 == F7_BASE) begin
                    illegal = 1'b0;
                    case (funct3)
                        3'b000:  alu_ctrl = AluAdd;
                        3'b001:  alu_ctrl = AluSll;
                        3'b010:  alu_ctrl = AluSlt;
                        3'b011:  alu_ctrl = AluSltu;
                        3'b100:  alu_ctrl = AluXor;
                        3'b101:  alu_ctrl = AluSrl;
                        3'b110:  alu_ctrl = AluOr;
                        3'b111:  alu_ctrl = AluAnd;
                        default: alu_ctrl = AluIllegal;
                    endcase
                end else if (funct7 == F7_ALT && funct3 == 3'b000) begin
                    illegal  = 1'b0;
                    alu_ctrl = AluSub;
                end else if (funct7 == F7_ALT && funct3 == 3'b101) begin
                    illegal  = 1'b0;
                    alu_ctrl = AluSra;
                end
            end
            OPC_OPIMM: begin
                case (funct3)
                    3'b000: begin
                        illegal  = 1'b0;
                        alu_ctrl = AluAdd;
                    end
                    3'b010: begin
                        illegal  = 1'b0;
                        alu_ctrl = AluSlt;
                    end
                    3'b011: begin
                        illegal  = 1'b0;
                        alu_ctrl = AluSltu;
                    end
                    3'b100: begin
                        illegal  = 1'b0;
                        alu_ctrl = AluXor;
                    end
                    3'b110: begin
                        illegal  = 1'b0;
                        alu_ctrl = AluOr;
                    end
                    3'b111: begin
                        illegal  = 1'b0;
                        alu_ctrl = AluAnd;
                    end
                    3'b001: begin
                        if (funct7 == F7_BASE) begin
                            illegal  = 1'b0;
                            alu_ctrl = AluSll;
                        end
                    end
                    3'b101: begin
                        if (funct7 == F7_BASE) begin
                            illegal  = 1'b0;
                            alu_ctrl = AluSrl;
                        end else if (funct7 == F7_ALT) begin
                            illegal  = 1'b0;
                            alu_ctrl = AluSra;
                        end
                    end
                    default: begin
                        illegal  = 1'b1;
                        alu_ctrl = AluIllegal;
                    end
                endcase
            end
            default: begin
                illegal  = 1'b1;
                alu_ctrl = AluIllegal;
            end
        endcase
    end

endmodule

// File: rtl/alu_issue_stage.sv
// Decode-to-execute issue stage: ALU control decode, operand-B mux and a
// 2-entry skid buffer (output register + skid register) with flush.
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [6:0]      in_opcode,
    input  logic [2:0]      in_funct3,
    input  logic [6:0]      in_funct7,
    input  logic [XLEN-1:0] in_rs1,
    input  logic [XLEN-1:0] in_rs2,
    input  logic [XLEN-1:0] in_imm,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_rs1,
    output logic [XLEN-1:0] out_op2,
    output logic [3:0]      out_alu_ctrl,
    output logic            out_illegal
);

    typedef struct packed {
        logic [XLEN-1:0] rs1;
        logic [XLEN-1:0] op2;
        alu_ctrl_t       alu_ctrl;
        logic            illegal;
    } entry_t;

    alu_ctrl_t dec_alu_ctrl;
    logic      dec_illegal;
    logic      dec_use_imm;

    alu_ctrl_decode u_decode (
        .opcode   (in_opcode),
        .funct3   (in_funct3),
        .funct7   (in_funct7),
        .alu_ctrl (dec_alu_ctrl),
        .illegal  (dec_illegal),
        .use_imm  (dec_use_imm)
    );

    entry_t in_entry;
    entry_t out_q, out_d;
    entry_t skid_q, skid_d;
    logic   out_valid_q, out_valid_d;
    logic   skid_valid_q, skid_valid_d;
    logic   accept;
    logic   out_load;

    always_comb begin
        in_entry.rs1      = in_rs1;
        in_entry.op2      = dec_use_imm ? in_imm : in_rs2;
        in_entry.alu_ctrl = dec_alu_ctrl;
        in_entry.illegal  = dec_illegal;
    end

    // in_ready depends only on registered state, never on out_ready.
    assign in_ready = !skid_valid_q;
    assign accept   = in_valid && in_ready;
    assign out_load = !out_valid_q || out_ready;

    always_comb begin
        out_d        = out_q;
        skid_d       = skid_q;
        out_valid_d  = out_valid_q;
        skid_valid_d = skid_valid_q;

        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (out_load) begin
            if (skid_valid_q) begin
                // Skid full implies no accept this cycle, so the skid simply drains.
                out_d        = skid_q;
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
            end else begin
                out_valid_d = accept;
                if (accept) begin
                    out_d = in_entry;
                end
            end
        end else if (accept) begin
            skid_d       = in_entry;
            skid_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q        <= '0;
            skid_q       <= '0;
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
        end else begin
            out_q        <= out_d;
            skid_q       <= skid_d;
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign out_rs1      = out_q.rs1;
    assign out_op2      = out_q.op2;
    assign out_alu_ctrl = out_q.alu_ctrl;
    assign out_illegal  = out_q.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: rule-table decode model plus FIFO occupancy model,
// checked every cycle, with directed vectors and literal expectations.
module tb_alu_issue_stage;

    localparam logic [6:0] OP    = 7'b0110011;
    localparam logic [6:0] OPIMM = 7'b0010011;
    localparam logic [6:0] FB    = 7'b0000000;
    localparam logic [6:0] FA    = 7'b0100000;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  in_opcode;
    logic [2:0]  in_funct3;
    logic [6:0]  in_funct7;
    logic [31:0] in_rs1;
    logic [31:0] in_rs2;
    logic [31:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_rs1;
    logic [31:0] out_op2;
    logic [3:0]  out_alu_ctrl;
    logic        out_illegal;

    alu_issue_stage #(.XLEN(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_opcode    (in_opcode),
        .in_funct3    (in_funct3),
        .in_funct7    (in_funct7),
        .in_rs1       (in_rs1),
        .in_rs2       (in_rs2),
        .in_imm       (in_imm),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_rs1      (out_rs1),
        .out_op2      (out_op2),
        .out_alu_ctrl (out_alu_ctrl),
        .out_illegal  (out_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [6:0] opc;
        logic [2:0] f3;
        logic [6:0] f7;
        bit         any_f7;
        logic [3:0] code;
    } rule_t;

    typedef struct {
        logic [31:0] rs1;
        logic [31:0] op2;
        logic [3:0]  ctrl;
        logic        ill;
    } exp_t;

    rule_t rules[$];
    exp_t  model_q[$];
    int    n_checks = 0;
    int    n_fail   = 0;

    function automatic void add_rule(input logic [6:0] opc, input logic [2:0] f3,
                                     input logic [6:0] f7, input bit any_f7,
                                     input logic [3:0] code);
        rule_t r;
        r.opc = opc; r.f3 = f3; r.f7 = f7; r.any_f7 = any_f7; r.code = code;
        rules.push_back(r);
    endfunction

    // The complete list of legal encodings; everything else decodes to 1111.
    function automatic void init_rules();
        add_rule(OP, 3'd0, FB, 0, 4'b0000);
        add_rule(OP, 3'd0, FA, 0, 4'b0001);
        add_rule(OP, 3'd1, FB, 0, 4'b0101);
        add_rule(OP, 3'd2, FB, 0, 4'b1000);
        add_rule(OP, 3'd3, FB, 0, 4'b1001);
        add_rule(OP, 3'd4, FB, 0, 4'b0100);
        add_rule(OP, 3'd5, FB, 0, 4'b0110);
        add_rule(OP, 3'd5, FA, 0, 4'b0111);
        add_rule(OP, 3'd6, FB, 0, 4'b0011);
        add_rule(OP, 3'd7, FB, 0, 4'b0010);
        add_rule(OPIMM, 3'd0, FB, 1, 4'b0000);
        add_rule(OPIMM, 3'd2, FB, 1, 4'b1000);
        add_rule(OPIMM, 3'd3, FB, 1, 4'b1001);
        add_rule(OPIMM, 3'd4, FB, 1, 4'b0100);
        add_rule(OPIMM, 3'd6, FB, 1, 4'b0011);
        add_rule(OPIMM, 3'd7, FB, 1, 4'b0010);
        add_rule(OPIMM, 3'd1, FB, 0, 4'b0101);
        add_rule(OPIMM, 3'd5, FB, 0, 4'b0110);
        add_rule(OPIMM, 3'd5, FA, 0, 4'b0111);
    endfunction

    function automatic exp_t expect_entry(input logic [6:0] opc, input logic [2:0] f3,
                                          input logic [6:0] f7, input logic [31:0] rs1,
                                          input logic [31:0] rs2, input logic [31:0] imm);
        exp_t e;
        e.rs1  = rs1;
        e.op2  = (opc == OPIMM) ? imm : rs2;
        e.ctrl = 4'b1111;
        e.ill  = 1'b1;
        foreach (rules[i]) begin
            if (rules[i].opc == opc && rules[i].f3 == f3 &&
                (rules[i].any_f7 || rules[i].f7 == f7)) begin
                e.ctrl = rules[i].code;
                e.ill  = 1'b0;
            end
        end
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: FIFO of at most two issued entries.
    bit can_accept;
    always @(posedge clk or posedge rst) begin
        if (rst || flush) begin
            model_q.delete();
        end else begin
            can_accept = model_q.size() < 2;
            if (model_q.size() != 0 && out_ready) void'(model_q.pop_front());
            if (in_valid && can_accept)
                model_q.push_back(expect_entry(in_opcode, in_funct3, in_funct7,
                                               in_rs1, in_rs2, in_imm));
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            check("rst_out_valid", 32'(out_valid), 32'd0);
            check("rst_in_ready", 32'(in_ready), 32'd1);
            check("rst_out_rs1", out_rs1, 32'd0);
            check("rst_out_op2", out_op2, 32'd0);
            check("rst_ctrl", 32'(out_alu_ctrl), 32'd0);
            check("rst_illegal", 32'(out_illegal), 32'd0);
        end else begin
            check("in_ready", 32'(in_ready), 32'(model_q.size() < 2));
            check("out_valid", 32'(out_valid), 32'(model_q.size() != 0));
            if (model_q.size() != 0) begin
                check("out_rs1", out_rs1, model_q[0].rs1);
                check("out_op2", out_op2, model_q[0].op2);
                check("out_alu_ctrl", 32'(out_alu_ctrl), 32'(model_q[0].ctrl));
                check("out_illegal", 32'(out_illegal), 32'(model_q[0].ill));
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic present(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                           input logic [31:0] rs1, input logic [31:0] rs2,
                           input logic [31:0] imm);
        in_valid  = 1'b1;
        in_opcode = opc;
        in_funct3 = f3;
        in_funct7 = f7;
        in_rs1    = rs1;
        in_rs2    = rs2;
        in_imm    = imm;
    endtask

    initial begin
        init_rules();
        rst = 1'b1; flush = 1'b0; out_ready = 1'b1; in_valid = 1'b0;
        in_opcode = '0; in_funct3 = '0; in_funct7 = '0;
        in_rs1 = '0; in_rs2 = '0; in_imm = '0;
        step();
        rst = 1'b0;

        // Main decode function with literal expectations.
        present(OP, 3'b111, FB, 32'hA5A5F0F0, 32'h0F0FA5A5, 32'h00001234);
        step();
        check("and_valid", 32'(out_valid), 32'd1);
        check("and_ctrl", 32'(out_alu_ctrl), 32'b0010);
        check("and_op2", out_op2, 32'h0F0FA5A5);
        check("and_rs1", out_rs1, 32'hA5A5F0F0);
        present(OPIMM, 3'b110, 7'h55, 32'h01234567, 32'hDEADBEEF, 32'hFFFF0000);
        step();
        check("ori_ctrl", 32'(out_alu_ctrl), 32'b0011);
        check("ori_op2", out_op2, 32'hFFFF0000);
        present(OPIMM, 3'b100, FB, 32'h1, 32'h2, 32'h000000FF);
        step();
        check("xori_ctrl", 32'(out_alu_ctrl), 32'b0100);
        present(OP, 3'b000, FA, 32'h5, 32'h6, 32'h7);
        step();
        check("sub_ctrl", 32'(out_alu_ctrl), 32'b0001);
        present(OPIMM, 3'b101, FA, 32'h5, 32'h6, 32'h7);
        step();
        check("srai_ctrl", 32'(out_alu_ctrl), 32'b0111);
        check("srai_op2", out_op2, 32'h7);

        // Illegal encodings still issue with operands passed through.
        present(OP, 3'b110, FA, 32'h11, 32'h22, 32'h33);
        step();
        check("ill_op_ctrl", 32'(out_alu_ctrl), 32'b1111);
        check("ill_op_flag", 32'(out_illegal), 32'd1);
        check("ill_op_op2", out_op2, 32'h22);
        present(7'b0000011, 3'b000, FB, 32'h44, 32'h55, 32'h66);
        step();
        check("ill_load_ctrl", 32'(out_alu_ctrl), 32'b1111);
        check("ill_load_flag", 32'(out_illegal), 32'd1);
        present(OPIMM, 3'b001, FA, 32'h77, 32'h88, 32'h99);
        step();
        check("ill_slli_ctrl", 32'(out_alu_ctrl), 32'b1111);
        check("ill_slli_flag", 32'(out_illegal), 32'd1);

        // Encoding sweep, back-to-back.
        for (int o = 0; o < 2; o++) begin
            for (int k = 0; k < 3; k++) begin
                for (int f = 0; f < 8; f++) begin
                    present((o == 0) ? OP : OPIMM, 3'(f),
                            (k == 0) ? FB : ((k == 1) ? FA : 7'h01),
                            32'(o * 100 + k * 10 + f), $urandom, $urandom);
                    step();
                end
            end
        end
        in_valid = 1'b0;
        step();

        // Backpressure: in_ready falls after the second entry, then ordered drain.
        out_ready = 1'b0;
        present(OP, 3'b000, FB, 32'hAAAA0001, 32'h1, 32'h0);
        step();
        check("bp_ready_a", 32'(in_ready), 32'd1);
        present(OP, 3'b100, FB, 32'hAAAA0002, 32'h2, 32'h0);
        step();
        check("bp_ready_b", 32'(in_ready), 32'd0);
        check("bp_hold_a", out_rs1, 32'hAAAA0001);
        present(OP, 3'b110, FB, 32'hAAAA0003, 32'h3, 32'h0);
        step();
        check("bp_full_ready", 32'(in_ready), 32'd0);
        check("bp_full_hold", out_rs1, 32'hAAAA0001);
        out_ready = 1'b1;
        step();
        check("bp_drain_b", out_rs1, 32'hAAAA0002);
        check("bp_ready_rise", 32'(in_ready), 32'd1);
        step();
        check("bp_drain_c", out_rs1, 32'hAAAA0003);
        in_valid = 1'b0;
        step();
        check("bp_empty", 32'(out_valid), 32'd0);

        // Flush with both entries full and in_valid high.
        out_ready = 1'b0;
        present(OP, 3'b000, FB, 32'hD0, 32'h1, 32'h0);
        step();
        present(OP, 3'b000, FB, 32'hE0, 32'h1, 32'h0);
        step();
        present(OP, 3'b000, FB, 32'hF0, 32'h1, 32'h0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        check("fl_valid", 32'(out_valid), 32'd0);
        check("fl_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        step();
        check("fl_nothing", 32'(out_valid), 32'd0);

        // Flush discards an entry accepted in the same cycle.
        out_ready = 1'b0;
        present(OP, 3'b000, FB, 32'hC0, 32'h1, 32'h0);
        step();
        present(OP, 3'b000, FB, 32'hC1, 32'h1, 32'h0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        check("fl2_valid", 32'(out_valid), 32'd0);
        out_ready = 1'b1;
        step();
        check("fl2_nothing", 32'(out_valid), 32'd0);

        // Asynchronous reset mid-cycle with entries buffered.
        out_ready = 1'b0;
        present(OPIMM, 3'b111, FB, 32'h12345678, 32'h1, 32'hCAFEF00D);
        step();
        present(OP, 3'b001, FB, 32'h87654321, 32'h2, 32'h0);
        step();
        in_valid = 1'b0;
        check("ar_full", 32'(in_ready), 32'd0);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("ar_valid", 32'(out_valid), 32'd0);
        check("ar_ready", 32'(in_ready), 32'd1);
        check("ar_rs1", out_rs1, 32'd0);
        check("ar_op2", out_op2, 32'd0);
        check("ar_ctrl", 32'(out_alu_ctrl), 32'd0);
        @(negedge clk);
        #1 rst = 1'b0;
        out_ready = 1'b1;
        present(OP, 3'b010, FB, 32'h0BADBEEF, 32'h3, 32'h0);
        step();
        check("ar_restart_valid", 32'(out_valid), 32'd1);
        check("ar_restart_rs1", out_rs1, 32'h0BADBEEF);
        check("ar_restart_ctrl", 32'(out_alu_ctrl), 32'b1000);
        in_valid = 1'b0;
        step();
        check("ar_restart_done", 32'(out_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_issue_stage.md
# alu_issue_stage

Decode-to-execute issue stage that produces the `alu_ctrl` code and operands consumed by the execute-stage ALU units, including the logical unit (AND/OR/XOR). It decodes RV32I OP and OP-IMM instructions into the 4-bit ALU control encoding and selects operand B (rs2 or immediate). Results are registered into the ID/EX boundary through a 2-entry skid buffer with valid/ready handshakes on both sides and a synchronous flush.

## Interface
- `XLEN`, 32, operand width
- `clk` input 1: single clock, rising edge
- `rst` input 1: asynchronous, active-high reset
- `flush` input 1: synchronous kill of all buffered entries
- `in_valid` input 1: decode presents an instruction
- `in_ready` output 1: stage can accept (`!skid_full`)
- `in_opcode` input 7, `in_funct3` input 3, `in_funct7` input 7: instruction fields
- `in_rs1` input XLEN, `in_rs2` input XLEN, `in_imm` input XLEN: register data, sign-extended immediate
- `out_valid` output 1: execute entry valid
- `out_ready` input 1: execute consumes entry
- `out_rs1` output XLEN: operand A
- `out_op2` output XLEN: operand B (rs2 for OP, imm for OP-IMM)
- `out_alu_ctrl` output 4: ALU control code
- `out_illegal` output 1: instruction not decodable by this stage

## Operation
- ALU codes: ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, SLL 0101, SRL 0110, SRA 0111, SLT 1000, SLTU 1001, ILLEGAL 1111; other codes are never produced.
- OP (0110011), funct3 → code: 000 ADD (funct7 0000000) / SUB (0100000); 001 SLL; 010 SLT; 011 SLTU; 100 XOR; 101 SRL (0000000) / SRA (0100000); 110 OR; 111 AND. funct7 = 0100000 is legal only for funct3 000/101; any other funct7 is illegal.
- OP-IMM (0010011): 000 ADDI, 010 SLTI, 011 SLTIU, 100 XORI, 110 ORI, 111 ANDI (funct7 ignored); 001 SLLI requires funct7 0000000; 101 SRLI (0000000) / SRAI (0100000); anything else is illegal.
- Any other opcode is illegal.
- On illegal: `out_alu_ctrl` = 1111 (logical unit yields 0), `out_illegal` = 1, operands pass through unchanged, and the entry is still issued.
- The skid buffer holds an output register plus one skid register. Accept occurs when `in_valid && in_ready`.
  - Output register loads when `!out_valid || out_ready`: from skid if skid full, else from input.
  - Accept while the output is stalled (`out_valid && !out_ready`) and skid is empty: the entry goes to skid.
- Ordering is strict FIFO; no entry is dropped or duplicated.
- `flush`: at the next edge both valids clear. An input accepted in the flush cycle is discarded. `flush` has priority over all loads.

## Timing
- Reset (async assert, sync deassert by the SoC):
  - `out_valid` = 0, skid empty, `in_ready` = 1.
  - `out_rs1`/`out_op2` = 0, `out_alu_ctrl` = 0000, `out_illegal` = 0.
- Latency: 1 cycle from accept to `out_valid` when the pipe is empty.
- Throughput: 1 instruction per cycle while `out_ready` = 1.
- `in_ready` is a registered-state function (skid empty), with no combinational path from `out_ready`. It drops the cycle after skid fills and rises the cycle after skid drains.
- Full (out + skid valid, `out_ready` = 0): `in_ready` = 0 and contents hold.
- Simultaneous accept and consume with empty skid: the output register reloads in the same edge with no bubble.
- Output data is stable while `out_valid && !out_ready`.
- Reset asserted mid-stream: all entries are lost immediately (async) and outputs take reset values.

## Structure
- Package `alu_pkg` holds:
  - `alu_ctrl_t` codes (as above), shared with the logical, arithmetic and shift units.
  - Opcode constants `OPC_OP` and `OPC_OPIMM`.
  - funct7 constants `F7_BASE` and `F7_ALT`.
- Sub-module `alu_ctrl_decode` is purely combinational: it maps opcode/funct3/funct7 to `{alu_ctrl, illegal, use_imm}`.
- The top level contains the mux and the skid buffer.

## Test plan
- Reset, then OP funct3=111 funct7=0, rs1=A5A5F0F0, rs2=0F0FA5A5 → next cycle `out_valid` = 1, ctrl 0010, op2 0F0FA5A5.
- OP-IMM funct3=110, imm=FFFF0000 → ctrl 0011, `out_op2` = FFFF0000. funct3=100 → ctrl 0100.
- Illegal cases:
  - OP funct3=110 funct7=0100000 → ctrl 1111, illegal = 1.
  - opcode 0000011 → ctrl 1111, illegal = 1.
  - OP-IMM funct3=001 funct7=0100000 → ctrl 1111, illegal = 1.
- Backpressure:
  - `out_ready` = 0, send 3 back-to-back instructions → `in_ready` falls after the 2nd.
  - Then `out_ready` = 1 → all issue in order, one per cycle.
- Flush with both entries full plus `in_valid` high → next cycle `out_valid` = 0, `in_ready` = 1, and none of the 3 entries appear.
- Async `rst` pulse mid-cycle with entries buffered → outputs immediately at reset values; the stream restarts cleanly.
